// File: rtl/spi_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_cmd_scheduler
// Purpose  : Shares the SPI master's 32-bit command buffer between NREQ
//            requesters. One command at a time is granted round-robin, written
//            into the next buffer slot through port A, and polled until the
//            SPI master sets the ready bit. The slot is then cleared and the
//            result is returned to the requester.
//            Command word: [31] ready, [30] busy/valid, [29] R/Wn (1 = read),
//            [14:7] data, [6:0] SPI memory address.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_rw/req_addr/req_wdata : requester side
//            rsp_valid/rsp_id/rsp_rdata/rsp_err            : response strobe
//            bufa_addr/bufa_wdata/bufa_we/bufa_rdata       : buffer port A
//            busy : high whenever a command is in flight
// Config   : SPI_SCHED_TIMEOUT_EN - when defined, polling gives up after
//            TMO_CYC cycles and answers with rsp_err=1. When undefined,
//            polling is unbounded and rsp_err is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_scheduler #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 8,
    parameter int TMO_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [1:0]          rsp_id,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   bufa_addr,
    output logic [31:0]         bufa_wdata,
    output logic                bufa_we,
    input  logic [31:0]         bufa_rdata,
    output logic                busy
);

    localparam int c_TMO_W = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_WRITE    = 3'd2,
        S_POLL_RD  = 3'd3,
        S_POLL_CHK = 3'd4,
        S_CLEAR    = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [1:0]          r_last_grant;
    logic [1:0]          r_grant;
    logic                r_rw;
    logic [7:0]          r_rdata;
    logic                r_tmo_hit;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [NREQ-1:0]     r_req_ready;
    logic                r_rsp_valid;
    logic [1:0]          r_rsp_id;
    logic [7:0]          r_rsp_rdata;
    logic                r_rsp_err;
    logic [31:0]         r_bufa_wdata;
    logic                r_bufa_we;
    logic                r_busy;

    logic                w_found;
    logic [1:0]          w_grant;
    logic [NREQ-1:0]     w_grant_onehot;
    logic                w_sel_rw;
    logic [6:0]          w_sel_addr;
    logic [7:0]          w_sel_wdata;
    logic [c_TMO_W-1:0]  w_tmo_next;
    logic                w_tmo_expired;
    logic                w_unused_rdata;

    // Round-robin pick: the lowest requester above last_grant wins; if none,
    // wrap around and take the lowest requester at or below last_grant. The
    // second loop runs last so any hit above last_grant overrides the wrap.
    always_comb begin
        w_found        = 1'b0;
        w_grant        = '0;
        w_grant_onehot = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i <= int'(r_last_grant))) begin
                w_found = 1'b1;
                w_grant = 2'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(r_last_grant))) begin
                w_found = 1'b1;
                w_grant = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_grant_onehot[i] = (w_grant == 2'(i));
        end
    end

    // Fields of the granted requester, selected by the registered grant.
    always_comb begin
        w_sel_rw    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == 2'(i)) begin
                w_sel_rw    = req_rw[i];
                w_sel_addr  = req_addr[7*i +: 7];
                w_sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // The count includes the current poll cycle, so expiry fires in the
    // POLL_CHK cycle where the total number of poll cycles reaches TMO_CYC.
    assign w_tmo_next = r_tmo_cnt + c_TMO_W'(1);
`ifdef SPI_SCHED_TIMEOUT_EN
    assign w_tmo_expired = (w_tmo_next >= c_TMO_W'(TMO_CYC));
`else
    assign w_tmo_expired = 1'b0;
`endif

    // Only the ready bit and the data field of the polled word matter.
    assign w_unused_rdata = ^{bufa_rdata[30:15], bufa_rdata[6:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_last_grant <= 2'(NREQ - 1);
            r_grant      <= '0;
            r_rw         <= 1'b0;
            r_rdata      <= '0;
            r_tmo_hit    <= 1'b0;
            r_tmo_cnt    <= '0;
            r_req_ready  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_bufa_wdata <= '0;
            r_bufa_we    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_grant;
                        r_req_ready <= w_grant_onehot;
                        r_busy      <= 1'b1;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Transfer edge: fields are taken even if req_valid fell
                    // during this cycle. Reads carry a zero data field.
                    r_req_ready  <= '0;
                    r_last_grant <= r_grant;
                    r_rw         <= w_sel_rw;
                    r_rdata      <= '0;
                    r_tmo_hit    <= 1'b0;
                    r_bufa_we    <= 1'b1;
                    r_bufa_wdata <= {1'b0, 1'b1, w_sel_rw, 14'd0,
                                     (w_sel_rw ? 8'd0 : w_sel_wdata), w_sel_addr};
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    r_bufa_we    <= 1'b0;
                    r_bufa_wdata <= '0;
                    r_tmo_cnt    <= '0;
                    r_state      <= S_POLL_RD;
                end
                S_POLL_RD: begin
                    r_tmo_cnt <= w_tmo_next;
                    r_state   <= S_POLL_CHK;
                end
                S_POLL_CHK: begin
                    r_tmo_cnt <= w_tmo_next;
                    // Ready takes priority over a timeout expiring this cycle.
                    if (bufa_rdata[31]) begin
                        if (r_rw) begin
                            r_rdata <= bufa_rdata[14:7];
                        end
                        r_bufa_we <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else if (w_tmo_expired) begin
                        r_tmo_hit <= 1'b1;
                        r_bufa_we <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_state <= S_POLL_RD;
                    end
                end
                S_CLEAR: begin
                    r_bufa_we   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_grant;
                    r_rsp_rdata <= r_rdata;
                    r_rsp_err   <= r_tmo_hit;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_id    <= '0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= '0;
                    r_bufa_we   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign bufa_addr  = r_wr_ptr;
    assign bufa_wdata = r_bufa_wdata;
    assign bufa_we    = r_bufa_we;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_scheduler
// Purpose  : Self-checking bench for spi_cmd_scheduler with a behavioural
//            command buffer and SPI master model. Expected responses are
//            queued when a request is driven and checked when it returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_scheduler;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 8;
    localparam int TMO    = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_rw = '0;
    logic [7*NREQ-1:0]   req_addr = '0;
    logic [8*NREQ-1:0]   req_wdata = '0;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [7:0]          rsp_rdata;
    logic                rsp_err;
    logic [ADDR_W-1:0]   bufa_addr;
    logic [31:0]         bufa_wdata;
    logic                bufa_we;
    logic [31:0]         bufa_rdata;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [1:0] id; logic [7:0] rdata; logic err; } rsp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;

    rsp_t exp_q[$];
    rsp_t rsp_log[$];
    wr_t  wr_log[$];
    int   grant_log[$];
    int   overlap_cnt = 0;
    int   tb_last = NREQ - 1;

    // Buffer + SPI master model
    bit [31:0]         mem [DEPTH];
    int                m_delay = 4;
    logic [7:0]        m_data  = 8'h00;
    bit                m_never = 1'b0;
    bit                m_busy  = 1'b0;
    logic [ADDR_W-1:0] m_slot  = '0;
    int                m_cnt   = 0;
    logic              m_rd    = 1'b0;

    spi_cmd_scheduler #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .TMO_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bufa_addr (bufa_addr),
        .bufa_wdata(bufa_wdata),
        .bufa_we   (bufa_we),
        .bufa_rdata(bufa_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bufa_we) mem[bufa_addr] <= bufa_wdata;
        bufa_rdata <= mem[bufa_addr];
        if (rst) begin
            m_busy <= 1'b0;
        end else if (bufa_we && bufa_wdata[30]) begin
            m_busy <= 1'b1;
            m_slot <= bufa_addr;
            m_cnt  <= m_delay;
            m_rd   <= bufa_wdata[29];
        end else if (m_busy && !m_never) begin
            if (m_cnt == 0) begin
                mem[m_slot] <= mem[m_slot] | 32'h8000_0000 | (m_rd ? {17'd0, m_data, 7'd0} : 32'd0);
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bufa_we) wr_log.push_back('{bufa_addr, bufa_wdata});
        if (rsp_valid) rsp_log.push_back('{rsp_id, rsp_rdata, rsp_err});
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
        if ($countones(req_ready) > 1) overlap_cnt++;
    end

    // Command word from the documented field layout.
    function automatic logic [31:0] cmd_word(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        return {1'b0, 1'b1, rw, 14'd0, (rw ? 8'd0 : wdata), addr};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rsp_log.delete();
        grant_log.delete();
    endtask

    // Raise a request and hold it until its grant; lat = cycles to req_ready.
    task automatic issue(input int id, input logic rw, input logic [6:0] addr,
                         input logic [7:0] wdata, output int lat);
        req_rw[id]           = rw;
        req_addr[7*id +: 7]  = addr;
        req_wdata[8*id +: 8] = wdata;
        req_valid[id]        = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!req_ready[id] && lat < 20);
        if (req_ready[id]) tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input int n, output bit ok);
        int k = 0;
        while (rsp_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (rsp_log.size() >= n);
    endtask

    task automatic test_reset();
        logic [55:0] obs;
        rst = 1'b1;
        tick();
        tick();
        obs = {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, bufa_addr, bufa_wdata, bufa_we, busy};
        n_tests++;
        if (obs !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
        tb_last = NREQ - 1;
    endtask

    task automatic test_write();
        int   lat;
        bit   ok;
        rsp_t e, o;
        m_delay = 20; m_never = 1'b0; m_data = 8'h00;
        clear_logs();
        exp_q.push_back('{2'd0, 8'h00, 1'b0});
        issue(0, 1'b0, 7'h05, 8'hA5, lat);
        n_tests++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL write_ready_latency: got %0d expected 1", lat);
        end
        wait_rsp(200, 1, ok);
        n_tests++;
        if (!ok || wr_log.size() < 2) begin
            n_fail++;
            $display("FAIL write_no_rsp: rsp=%0d writes=%0d expected 1 and 2", rsp_log.size(), wr_log.size());
            return;
        end
        // [30]=1, [14:7]=A5, [6:0]=05
        n_tests++;
        if (wr_log[0].addr !== 8'd0 || wr_log[0].data !== 32'h4000_5285) begin
            n_fail++;
            $display("FAIL write_cmd_word: got slot %0d word %h expected slot 0 word 40005285", wr_log[0].addr, wr_log[0].data);
        end
        n_tests++;
        if (wr_log[1].addr !== 8'd0 || wr_log[1].data !== 32'h0) begin
            n_fail++;
            $display("FAIL write_clear: got slot %0d word %h expected slot 0 word 0", wr_log[1].addr, wr_log[1].data);
        end
        e = exp_q.pop_front();
        o = rsp_log.pop_front();
        n_tests++;
        if ({o.id, o.rdata, o.err} !== {e.id, e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL write_rsp: got id %0d rdata %h err %b expected id %0d rdata %h err %b", o.id, o.rdata, o.err, e.id, e.rdata, e.err);
        end
        tb_last = 0;
    endtask

    task automatic test_read();
        int   lat;
        bit   ok;
        rsp_t e, o;
        m_delay = 6; m_data = 8'h3C;
        clear_logs();
        exp_q.push_back('{2'd1, 8'h3C, 1'b0});
        issue(1, 1'b1, 7'h12, 8'hFF, lat);
        wait_rsp(200, 1, ok);
        n_tests++;
        if (!ok || wr_log.size() < 2) begin
            n_fail++;
            $display("FAIL read_no_rsp: rsp=%0d writes=%0d expected 1 and 2", rsp_log.size(), wr_log.size());
            return;
        end
        n_tests++;
        if (wr_log[0].addr !== 8'd1 || wr_log[0].data !== 32'h6000_0012) begin
            n_fail++;
            $display("FAIL read_cmd_word: got slot %0d word %h expected slot 1 word 60000012", wr_log[0].addr, wr_log[0].data);
        end
        n_tests++;
        if (wr_log[1].addr !== 8'd1 || wr_log[1].data !== 32'h0) begin
            n_fail++;
            $display("FAIL read_clear: got slot %0d word %h expected slot 1 word 0", wr_log[1].addr, wr_log[1].data);
        end
        e = exp_q.pop_front();
        o = rsp_log.pop_front();
        n_tests++;
        if ({o.id, o.rdata, o.err} !== {e.id, e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL read_rsp: got id %0d rdata %h err %b expected id %0d rdata %h err %b", o.id, o.rdata, o.err, e.id, e.rdata, e.err);
        end
        tb_last = 1;
    endtask

    task automatic test_arbitration();
        int   k;
        int   exp_id [4];
        bit   ok;
        rsp_t e, o;
        m_delay = 2; m_data = 8'h77;
        clear_logs();
        overlap_cnt = 0;
        for (int g = 0; g < 4; g++) begin
            exp_id[g] = (tb_last + 1 + g) % NREQ;
            exp_q.push_back('{2'(exp_id[g]), (exp_id[g] == 1) ? 8'h77 : 8'h00, 1'b0});
        end
        req_rw[0] = 1'b0; req_addr[6:0]  = 7'h21; req_wdata[7:0]  = 8'h11;
        req_rw[1] = 1'b1; req_addr[13:7] = 7'h22; req_wdata[15:8] = 8'h99;
        req_valid = 2'b11;
        k = 0;
        while (grant_log.size() < 4 && k < 300) begin
            tick();
            k++;
        end
        req_valid = 2'b00;
        wait_rsp(300, 4, ok);
        n_tests++;
        if (!ok || grant_log.size() != 4) begin
            n_fail++;
            $display("FAIL arb_progress: grants %0d rsps %0d expected 4 and 4", grant_log.size(), rsp_log.size());
            return;
        end
        for (int g = 0; g < 4; g++) begin
            n_tests++;
            if (grant_log[g] != exp_id[g]) begin
                n_fail++;
                $display("FAIL arb_grant%0d: got %0d expected %0d", g, grant_log[g], exp_id[g]);
            end
            e = exp_q.pop_front();
            o = rsp_log.pop_front();
            n_tests++;
            if ({o.id, o.rdata, o.err} !== {e.id, e.rdata, e.err}) begin
                n_fail++;
                $display("FAIL arb_rsp%0d: got id %0d rdata %h err %b expected id %0d rdata %h err %b", g, o.id, o.rdata, o.err, e.id, e.rdata, e.err);
            end
        end
        n_tests++;
        if (overlap_cnt != 0) begin
            n_fail++;
            $display("FAIL arb_ready_overlap: got %0d cycles expected 0", overlap_cnt);
        end
        tb_last = exp_id[3];
    endtask

    task automatic test_wrap();
        int           lat;
        int           nz;
        bit           ok;
        logic         rw;
        logic [6:0]   addr;
        logic [7:0]   wdata;
        logic [7:0]   last_slot;
        rsp_t         e, o;
        logic [90:0]  obs, expv;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_delay = 0; m_never = 1'b0;
        last_slot = 8'hFF;
        for (int c = 0; c < 257; c++) begin
            rw    = c[0];
            addr  = c[6:0];
            wdata = c[7:0] ^ 8'h5A;
            m_data = 8'(c * 3);
            clear_logs();
            exp_q.push_back('{2'd0, rw ? 8'(c * 3) : 8'h00, 1'b0});
            issue(0, rw, addr, wdata, lat);
            wait_rsp(100, 1, ok);
            e = exp_q.pop_front();
            if (ok && wr_log.size() >= 2) begin
                o = rsp_log.pop_front();
                obs = {wr_log[0].addr, wr_log[0].data, wr_log[1].addr, wr_log[1].data, o.id, o.rdata, o.err};
                last_slot = wr_log[0].addr;
            end else begin
                obs = '1;
            end
            expv = {8'(c % DEPTH), cmd_word(rw, addr, wdata), 8'(c % DEPTH), 32'h0, e.id, e.rdata, e.err};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL wrap_cmd%0d: got %h expected %h", c, obs, expv);
            end
        end
        n_tests++;
        if (last_slot !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_slot257: got slot %0d expected 0", last_slot);
        end
        nz = 0;
        for (int s = 0; s < DEPTH; s++) if (mem[s] != 32'h0) nz++;
        n_tests++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL wrap_slots_clean: got %0d dirty slots expected 0", nz);
        end
        tb_last = 0;
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          k;
        bit          ok;
        logic [55:0] obs;
        rsp_t        e, o;
        m_never = 1'b1;
        clear_logs();
        issue(1, 1'b0, 7'h33, 8'h44, lat);
        k = 0;
        while (wr_log.size() == 0 && k < 20) begin
            tick();
            k++;
        end
        tick();  // now in POLL_RD
        n_tests++;
        if (busy !== 1'b1 || bufa_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy %b we %b expected 1 0", busy, bufa_we);
        end
        rst = 1'b1;
        tick();
        obs = {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, bufa_addr, bufa_wdata, bufa_we, busy};
        n_tests++;
        if (obs !== 56'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h expected 0", obs);
        end
        rst = 1'b0;
        m_never = 1'b0; m_delay = 3;
        tick();
        n_tests++;
        if (rsp_log.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_aborted_rsp: got %0d responses expected 0", rsp_log.size());
        end
        clear_logs();
        exp_q.push_back('{2'd0, 8'h00, 1'b0});
        issue(0, 1'b0, 7'h01, 8'h5A, lat);
        wait_rsp(100, 1, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || wr_log.size() < 2) begin
            n_fail++;
            $display("FAIL rstmid_no_rsp: rsp=%0d writes=%0d expected 1 and 2", rsp_log.size(), wr_log.size());
            return;
        end
        n_tests++;
        if (wr_log[0].addr !== 8'd0 || wr_log[0].data !== cmd_word(1'b0, 7'h01, 8'h5A)) begin
            n_fail++;
            $display("FAIL rstmid_slot: got slot %0d word %h expected slot 0 word %h", wr_log[0].addr, wr_log[0].data, cmd_word(1'b0, 7'h01, 8'h5A));
        end
        o = rsp_log.pop_front();
        n_tests++;
        if ({o.id, o.rdata, o.err} !== {e.id, e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got id %0d rdata %h err %b expected id %0d rdata %h err %b", o.id, o.rdata, o.err, e.id, e.rdata, e.err);
        end
        tb_last = 0;
    endtask

    task automatic test_timeout();
        int   lat;
        bit   ok;
        m_never = 1'b1;
        clear_logs();
`ifdef SPI_SCHED_TIMEOUT_EN
        begin
            rsp_t e, o;
            exp_q.push_back('{2'd1, 8'h00, 1'b1});
            issue(1, 1'b1, 7'h40, 8'h00, lat);
            wait_rsp(TMO * 4 + 50, 1, ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || wr_log.size() < 2) begin
                n_fail++;
                $display("FAIL tmo_no_rsp: rsp=%0d writes=%0d expected 1 and 2", rsp_log.size(), wr_log.size());
            end else begin
                o = rsp_log.pop_front();
                n_tests++;
                if ({o.id, o.rdata, o.err} !== {e.id, e.rdata, e.err}) begin
                    n_fail++;
                    $display("FAIL tmo_rsp: got id %0d rdata %h err %b expected id %0d rdata %h err %b", o.id, o.rdata, o.err, e.id, e.rdata, e.err);
                end
                n_tests++;
                if (wr_log[1].addr !== wr_log[0].addr || wr_log[1].data !== 32'h0) begin
                    n_fail++;
                    $display("FAIL tmo_clear: got slot %0d word %h expected slot %0d word 0", wr_log[1].addr, wr_log[1].data, wr_log[0].addr);
                end
            end
        end
`else
        issue(1, 1'b1, 7'h40, 8'h00, lat);
        for (int k = 0; k < 200; k++) tick();
        n_tests++;
        if (busy !== 1'b1 || rsp_log.size() != 0) begin
            n_fail++;
            $display("FAIL notmo_hold: got busy %b rsps %0d expected busy 1 rsps 0", busy, rsp_log.size());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
        m_never = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
